dpram_rd_arbiter: RTL

Shares the read port of a single `dpram` instance among `NUM_REQ` requesters (e.g. coefficient fetch units in the memory-polynomial datapath) and exposes its write port to one loader. Requesters are arbitrated round-robin with valid/ready handshakes and may hold the grant for a multi-beat burst. Read data returns one cycle after acceptance, tagged by a one-hot valid. An optional post-reset sweep clears the RAM to zero. The block runs on one clock and instantiates `dpram` with `clka` and `clkb` both tied to `clk`.

---
 rtl/dpram_arb_pkg.sv | 26 ++
 rtl/dpram.sv | 26 ++
 rtl/dpram_rd_arbiter_rr_picker.sv | 14 +
 rtl/dpram_rd_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/dpram_arb_pkg.sv
// Shared types and the round-robin pick function for the dpram read arbiter.
package dpram_arb_pkg;

  typedef enum logic [1:0] {INIT, IDLE, BURST} arb_state_e;

  localparam int MAX_REQ = 8;
  localparam int PTR_W   = $clog2(MAX_REQ);

  // Unused upper requesters are zero, so a modulo-MAX_REQ scan from ptr
  // lands on the same winner as a modulo-NUM_REQ scan.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [PTR_W-1:0]   ptr);
    logic [MAX_REQ-1:0] grant;
    logic [PTR_W-1:0]   idx;
    grant = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      idx = ptr + PTR_W'(k);
      if (valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM: write port A, registered read port B, read-first on collision.
module dpram #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clka,
  input  logic                     wea,
  input  logic [ADDRESS_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0]    dina,
  input  logic                     clkb,
  input  logic                     reb,
  input  logic [ADDRESS_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0]    doutb
);

  logic [DATA_WIDTH-1:0] mem [0:2**ADDRESS_WIDTH-1];

  always_ff @(posedge clka) begin
    if (wea) mem[addra] <= dina;
  end

  always_ff @(posedge clkb) begin
    if (reb) doutb <= mem[addrb];
  end

endmodule

// File: rtl/dpram_rd_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first valid at or after ptr.
module rr_picker
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  assign grant = NUM_REQ'(rr_pick(MAX_REQ'(valid), ptr));

endmodule

// File: rtl/dpram_rd_arbiter.sv
// Round-robin, burst-capable arbiter for the read port of one dpram plus a loader write port.
// Optional post-reset RAM zeroing sweep: DPRAM_RD_ARBITER_INIT_CLEAR_EN.
module dpram_rd_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_REQ       = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [ADDRESS_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [NUM_REQ-1:0]               rd_req_valid,
  input  logic [NUM_REQ-1:0]               rd_req_last,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] rd_req_addr,
  output logic [NUM_REQ-1:0]               rd_req_ready,
  output logic [NUM_REQ-1:0]               rd_rsp_valid,
  output logic [DATA_WIDTH-1:0]            rd_rsp_data,
  output logic                             init_done
);

  localparam int AW    = ADDRESS_WIDTH;
  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         state, state_next;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_next, lock_idx, lock_idx_next, sel_idx, sel_inc;
  logic [NUM_REQ-1:0] pick, accept;
  logic               sel_last, clear_done;
  logic               wea, reb;
  logic [AW-1:0]      addra, addrb;
  logic [DATA_WIDTH-1:0] dina;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid (rd_req_valid),
    .ptr   (PTR_W'(rr_ptr)),
    .grant (pick)
  );

  always_comb begin
    rd_req_ready = '0;
    case (state)
      IDLE:    rd_req_ready = pick;
      BURST:   rd_req_ready[lock_idx] = 1'b1;
      default: rd_req_ready = '0;
    endcase
  end

  assign accept = rd_req_valid & rd_req_ready;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) sel_idx = IDX_W'(i);
    end
  end

  assign sel_last = rd_req_last[sel_idx];
  assign sel_inc  = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
  assign reb      = |accept;
  assign addrb    = rd_req_addr[sel_idx*AW +: AW];

  always_comb begin
    state_next    = state;
    rr_ptr_next   = rr_ptr;
    lock_idx_next = lock_idx;
    case (state)
      INIT: begin
        if (clear_done) state_next = IDLE;
      end
      IDLE: begin
        if (reb) begin
          if (sel_last) begin
            rr_ptr_next = sel_inc;
          end else begin
            lock_idx_next = sel_idx;
            state_next    = BURST;
          end
        end
      end
      BURST: begin
        if (reb && sel_last) begin
          state_next  = IDLE;
          rr_ptr_next = sel_inc;
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INIT;
      rr_ptr       <= '0;
      lock_idx     <= '0;
      rd_rsp_valid <= '0;
    end else begin
      state        <= state_next;
      rr_ptr       <= rr_ptr_next;
      lock_idx     <= lock_idx_next;
      rd_rsp_valid <= accept;
    end
  end

  assign wr_ready  = (state != INIT);
  assign init_done = (state != INIT);

`ifdef DPRAM_RD_ARBITER_INIT_CLEAR_EN
  // Extra MSB marks the sweep complete, giving one settle cycle before IDLE.
  logic [AW:0] clr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr <= '0;
    end else if (state == INIT && !clr_addr[AW]) begin
      clr_addr <= clr_addr + 1'b1;
    end
  end

  assign clear_done = clr_addr[AW];

  always_comb begin
    wea   = wr_valid & wr_ready;
    addra = wr_addr;
    dina  = wr_data;
    if (state == INIT) begin
      wea   = ~clr_addr[AW];
      addra = clr_addr[AW-1:0];
      dina  = '0;
    end
  end
`else
  assign clear_done = 1'b1;

  always_comb begin
    wea   = wr_valid & wr_ready;
    addra = wr_addr;
    dina  = wr_data;
  end
`endif

  dpram #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_dpram (
    .clka  (clk),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .clkb  (clk),
    .reb   (reb),
    .addrb (addrb),
    .doutb (rd_rsp_data)
  );

endmodule
